sfx_playback_scheduler: RTL and testbench

//  Shares the single audio ROM + codec write path among NUM_REQ game sound requesters (music, bomb drop,

---
 rtl/sfx_playback_scheduler_pkg.sv | 23 ++
 rtl/sfx_playback_scheduler_if.sv | 31 +++
 rtl/sfx_playback_scheduler_sample_tick_gen.sv | 36 +++
 rtl/sfx_playback_scheduler.sv | 212 +++++++++++++++++++++
 tb/tb_sfx_playback_scheduler.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sfx_playback_scheduler_pkg.sv
// Package: sfx_pkg
// Purpose: shared types and constants for the sound-effect playback scheduler.
//   - sfx_state_e : playback FSM states
//   - SFX_*       : requester / clip index assignments
//   - SFX_TICK_DIV: default CLOCK_50 cycles per sample tick (~44.1 kHz)
package sfx_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        CAPTURE = 3'd2,
        WRITE   = 3'd3,
        PLAY    = 3'd4
    } sfx_state_e;

    localparam int SFX_MUSIC   = 0;
    localparam int SFX_BOMB    = 1;
    localparam int SFX_EXPLODE = 2;
    localparam int SFX_DEATH   = 3;

    localparam int SFX_TICK_DIV = 1134;

endpackage

// File: rtl/sfx_playback_scheduler_if.sv
// Interface: sfx_playback_scheduler_if
// Purpose: bundles the audio ROM read path and the codec write path.
//   rom_addr        ROM address (scheduler -> ROM)
//   rom_q           ROM data, valid one cycle after rom_addr (ROM -> scheduler)
//   write_ready     codec FIFO has space (codec -> scheduler)
//   write           one-cycle write strobe (scheduler -> codec)
//   writedata_left  sample to codec
//   writedata_right same sample as left
// Modports: master = scheduler side, slave = ROM/codec side.
interface sfx_playback_scheduler_if #(
    parameter int ADDR_W = 14,
    parameter int ROM_W  = 16,
    parameter int OUT_W  = 24
);
    logic [ADDR_W-1:0] rom_addr;
    logic [ROM_W-1:0]  rom_q;
    logic              write_ready;
    logic              write;
    logic [OUT_W-1:0]  writedata_left;
    logic [OUT_W-1:0]  writedata_right;

    modport master (
        output rom_addr, write, writedata_left, writedata_right,
        input  rom_q, write_ready
    );

    modport slave (
        input  rom_addr, write, writedata_left, writedata_right,
        output rom_q, write_ready
    );
endinterface

// File: rtl/sfx_playback_scheduler_sample_tick_gen.sv
// Module: sample_tick_gen
// Purpose: free-running sample-rate divider. Counts 0..TICK_DIV-1 and flags
//          the cycle in which the count wraps.
// Ports:
//   clk      in  system clock
//   reset_n  in  synchronous active-low reset (counter to 0)
//   tick     out 1 during the cycle the counter wraps
module sample_tick_gen
    import sfx_pkg::*;
#(
    parameter int TICK_DIV = SFX_TICK_DIV,
    localparam int CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    logic [CNT_W-1:0] cnt_r;
    logic             wrap_s;

    assign wrap_s = (cnt_r == CNT_W'(TICK_DIV - 1));
    assign tick   = wrap_s;

    // Divider counter: wraps to zero after TICK_DIV-1.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_r <= '0;
        end else if (wrap_s) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

endmodule

// File: rtl/sfx_playback_scheduler.sv
// Module: sfx_playback_scheduler
// Purpose: shares one audio ROM and the codec write path among NUM_REQ sound
//          requesters. Trigger pulses are latched as pending, the highest
//          pending index is granted (and may preempt a lower one at a tick
//          boundary), the ROM is stepped once per sample tick and each sample
//          is scaled and handed to the codec. Silence is written every tick
//          while idle or while enable is low.
// Ports:
//   CLOCK_50   in   system clock
//   reset_n    in   synchronous active-low reset
//   enable     in   0 freezes the clip offset and writes silence
//   req        in   one-cycle trigger per requester
//   clip_base  in   packed start addresses, clip i at [i*ADDR_W +: ADDR_W]
//   clip_len   in   packed lengths in samples, 0 disables the clip
//   bus        ROM/codec interface (master side)
//   busy       out  a clip is in progress
//   active_id  out  index of the playing clip, 0 when idle
//   underrun   out  sticky: a tick arrived while a sample was still waiting
module sfx_playback_scheduler
    import sfx_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_W     = 14,
    parameter int ROM_W      = 16,
    parameter int OUT_W      = 24,
    parameter int GAIN_SHIFT = 5,
    parameter int TICK_DIV   = SFX_TICK_DIV,
    localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      CLOCK_50,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] clip_base,
    input  logic [NUM_REQ*ADDR_W-1:0] clip_len,
    sfx_playback_scheduler_if.master  bus,
    output logic                      busy,
    output logic [ID_W-1:0]           active_id,
    output logic                      underrun
);

    sfx_state_e        state_r, state_nx;
    logic [NUM_REQ-1:0] pending_r, pending_nx, grant_clr_s, len_nz_s;
    logic              busy_r, busy_nx, play_r, play_nx, underrun_r, underrun_nx;
    logic              tick_s, write_s, hi_valid_s, clip_last_s, do_grant_s;
    logic [ID_W-1:0]   active_id_r, active_id_nx, hi_id_s;
    logic [ADDR_W-1:0] base_r, base_nx, len_r, len_nx, offset_r, offset_nx;
    logic [ADDR_W-1:0] rom_addr_r, rom_addr_nx, grant_base_s, grant_len_s;
    logic [OUT_W-1:0]  sample_r, sample_nx;

    // Sign-extend a ROM word to codec width and apply the fixed gain.
    function automatic logic [OUT_W-1:0] scale_sample(input logic [ROM_W-1:0] q);
        logic [OUT_W-1:0] ext;
        ext = {{(OUT_W-ROM_W){q[ROM_W-1]}}, q};
        return ext << GAIN_SHIFT;
    endfunction

    sample_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk     (CLOCK_50),
        .reset_n (reset_n),
        .tick    (tick_s)
    );

    // Highest-index pending requester, and which slots currently accept triggers.
    always_comb begin
        hi_valid_s = 1'b0;
        hi_id_s    = '0;
        len_nz_s   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            hi_valid_s  = hi_valid_s | pending_r[i];
            hi_id_s     = pending_r[i] ? ID_W'(i) : hi_id_s;
            len_nz_s[i] = |clip_len[i*ADDR_W +: ADDR_W];
        end
    end

    assign grant_base_s = clip_base[hi_id_s*ADDR_W +: ADDR_W];
    assign grant_len_s  = clip_len[hi_id_s*ADDR_W +: ADDR_W];
    // Compared one bit wider so a zero length granted after a late change still ends.
    assign clip_last_s  = ({1'b0, offset_r} + {{ADDR_W{1'b0}}, 1'b1}) >= {1'b0, len_r};

    // Next-state and datapath updates for the playback FSM.
    always_comb begin
        state_nx     = state_r;
        busy_nx      = busy_r;
        play_nx      = play_r;
        active_id_nx = active_id_r;
        base_nx      = base_r;
        len_nx       = len_r;
        offset_nx    = offset_r;
        rom_addr_nx  = rom_addr_r;
        sample_nx    = sample_r;
        grant_clr_s  = '0;
        write_s      = 1'b0;
        do_grant_s   = 1'b0;
        // A tick that lands while the codec is still refusing the sample is lost.
        underrun_nx  = underrun_r | (tick_s & ~bus.write_ready & (state_r == WRITE));

        case (state_r)
            IDLE: begin
                if (hi_valid_s) begin
                    do_grant_s = 1'b1;
                    state_nx   = PLAY;
                end else if (tick_s) begin
                    // Silent pass keeps the codec fed with zeros.
                    play_nx     = 1'b0;
                    rom_addr_nx = '0;
                    state_nx    = LOAD;
                end else begin
                    state_nx = IDLE;
                end
            end
            PLAY: begin
                if (tick_s) begin
                    play_nx  = enable;
                    state_nx = LOAD;
                    if (hi_valid_s && (hi_id_s > active_id_r)) begin
                        do_grant_s  = 1'b1;
                        rom_addr_nx = grant_base_s;
                    end else begin
                        rom_addr_nx = base_r + offset_r;
                    end
                end else begin
                    state_nx = PLAY;
                end
            end
            LOAD: begin
                state_nx = CAPTURE;
            end
            CAPTURE: begin
                sample_nx = play_r ? scale_sample(bus.rom_q) : '0;
                state_nx  = WRITE;
            end
            WRITE: begin
                if (bus.write_ready) begin
                    write_s = 1'b1;
                    if ((play_r && clip_last_s) || !busy_r) begin
                        // Clip finished (or silent pass): hand over with no idle gap.
                        if (hi_valid_s) begin
                            do_grant_s = 1'b1;
                            state_nx   = PLAY;
                        end else begin
                            busy_nx      = 1'b0;
                            active_id_nx = '0;
                            state_nx     = IDLE;
                        end
                    end else begin
                        offset_nx = play_r ? (offset_r + 1'b1) : offset_r;
                        state_nx  = PLAY;
                    end
                end else begin
                    state_nx = WRITE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        if (do_grant_s) begin
            busy_nx              = 1'b1;
            active_id_nx         = hi_id_s;
            base_nx              = grant_base_s;
            len_nx               = grant_len_s;
            offset_nx            = '0;
            grant_clr_s[hi_id_s] = 1'b1;
        end else begin
            grant_clr_s = '0;
        end

        // A new trigger wins over the clear, so a same-cycle replay stays queued.
        pending_nx = (pending_r & ~grant_clr_s) | (req & len_nz_s);
    end

    // State and datapath registers.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            pending_r   <= '0;
            busy_r      <= 1'b0;
            play_r      <= 1'b0;
            underrun_r  <= 1'b0;
            active_id_r <= '0;
            base_r      <= '0;
            len_r       <= '0;
            offset_r    <= '0;
            rom_addr_r  <= '0;
            sample_r    <= '0;
        end else begin
            state_r     <= state_nx;
            pending_r   <= pending_nx;
            busy_r      <= busy_nx;
            play_r      <= play_nx;
            underrun_r  <= underrun_nx;
            active_id_r <= active_id_nx;
            base_r      <= base_nx;
            len_r       <= len_nx;
            offset_r    <= offset_nx;
            rom_addr_r  <= rom_addr_nx;
            sample_r    <= sample_nx;
        end
    end

    // The strobe follows write_ready directly; reset suppresses it in the same cycle.
    assign bus.write           = write_s & reset_n;
    assign bus.rom_addr        = rom_addr_r;
    assign bus.writedata_left  = sample_r;
    assign bus.writedata_right = sample_r;
    assign busy                = busy_r;
    assign active_id           = active_id_r;
    assign underrun            = underrun_r;

endmodule

// File: tb/tb_sfx_playback_scheduler.sv
// Testbench: tb_sfx_playback_scheduler
// Purpose: directed checks of the playback scheduler with TICK_DIV=8, a
//          one-cycle behavioural ROM returning its own address, and a write
//          monitor that records every codec strobe.
module tb_sfx_playback_scheduler;
    import sfx_pkg::*;

    localparam int AW = 14;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            enable;
    logic [3:0]      req;
    logic [4*AW-1:0] clip_base;
    logic [4*AW-1:0] clip_len;
    logic            busy;
    logic [1:0]      active_id;
    logic            underrun;

    sfx_playback_scheduler_if #(.ADDR_W(14), .ROM_W(16), .OUT_W(24)) bus ();

    sfx_playback_scheduler #(.TICK_DIV(8)) dut (
        .CLOCK_50  (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .req       (req),
        .clip_base (clip_base),
        .clip_len  (clip_len),
        .bus       (bus),
        .busy      (busy),
        .active_id (active_id),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    // Behavioural ROM: one-cycle latency, data equals address.
    always @(posedge clk) bus.rom_q <= {2'b00, bus.rom_addr};

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Write monitor, sampled on the falling edge.
    logic [23:0] dq[$];
    logic [1:0]  iq[$];
    int          tq[$];
    int idle_n = 0, idle_nz = 0, idle_t_last = 0, idle_t_prev = 0, lr_bad = 0;

    always @(negedge clk) begin
        if (reset_n && bus.write) begin
            if (bus.writedata_left != bus.writedata_right) lr_bad = lr_bad + 1;
            if (busy) begin
                dq.push_back(bus.writedata_left);
                iq.push_back(active_id);
                tq.push_back(cyc_n);
            end else begin
                idle_n = idle_n + 1;
                if (bus.writedata_left != 24'd0) idle_nz = idle_nz + 1;
                idle_t_prev = idle_t_last;
                idle_t_last = cyc_n;
            end
        end
    end

    int checks_n = 0;
    int failures_n = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_n++;
        if (obs !== exp) begin
            failures_n++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [3:0] m);
        req = m;
        cyc(1);
        req = 4'b0000;
    endtask

    task automatic set_clip(input int i, input int b, input int l);
        clip_base[i*AW +: AW] = b[AW-1:0];
        clip_len[i*AW +: AW]  = l[AW-1:0];
    endtask

    task automatic clear_log();
        dq.delete();
        iq.delete();
        tq.delete();
    endtask

    task automatic wait_busy(input logic lvl, input int budget, input string tag);
        int k = 0;
        while (busy !== lvl && k < budget) begin
            cyc(1);
            k++;
        end
        check_val(tag, 32'(busy), 32'(lvl));
    endtask

    task automatic wait_wr(input int n, input int budget, input string tag);
        int k = 0;
        while (dq.size() < n && k < budget) begin
            cyc(1);
            k++;
        end
        check_val(tag, (dq.size() >= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Watchdog so the run can never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0, m0, zeros;
        logic [23:0] nz[$];
        int exp_pr[4] = '{9600, 9632, 6400, 6432};
        int exp_id[4] = '{2, 2, 0, 0};

        reset_n = 1'b0;
        enable  = 1'b1;
        req     = 4'b0000;
        clip_base = '0;
        clip_len  = '0;
        bus.write_ready = 1'b1;
        cyc(5);
        check_val("rst_write", 32'(bus.write), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
        check_val("rst_underrun", 32'(underrun), 32'd0);
        check_val("rst_active_id", 32'(active_id), 32'd0);
        check_val("rst_data", 32'(bus.writedata_left), 32'd0);
        reset_n = 1'b1;

        // Idle: zero written every 8 cycles.
        cyc(20);
        n0 = idle_n;
        cyc(32);
        check_val("idle_writes", 32'(idle_n - n0), 32'd4);
        check_val("idle_nonzero", 32'(idle_nz), 32'd0);
        check_val("idle_period", 32'(idle_t_last - idle_t_prev), 32'd8);

        // Trigger on a zero-length slot is ignored.
        clear_log();
        set_clip(SFX_BOMB, 100, 0);
        pulse(4'b0010);
        cyc(24);
        check_val("len0_busy", 32'(busy), 32'd0);
        check_val("len0_writes", 32'(dq.size()), 32'd0);

        // Single clip: base 100, length 3.
        clear_log();
        set_clip(SFX_BOMB, 100, 3);
        pulse(4'b0010);
        wait_busy(1'b1, 20, "single_start");
        check_val("single_id", 32'(active_id), 32'd1);
        wait_busy(1'b0, 100, "single_end");
        check_val("single_count", 32'(dq.size()), 32'd3);
        check_val("single_d0", 32'(dq[0]), 32'd3200);
        check_val("single_d1", 32'(dq[1]), 32'd3232);
        check_val("single_d2", 32'(dq[2]), 32'd3264);
        check_val("single_period", 32'(tq[1] - tq[0]), 32'd8);
        check_val("single_idle_id", 32'(active_id), 32'd0);

        // Priority: clips 0 and 2 together, 2 plays first, 0 follows one tick later.
        clear_log();
        set_clip(SFX_MUSIC, 200, 2);
        set_clip(SFX_EXPLODE, 300, 2);
        pulse(4'b0101);
        wait_busy(1'b1, 20, "prio_start");
        wait_busy(1'b0, 200, "prio_end");
        check_val("prio_count", 32'(dq.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("prio_d%0d", i), 32'(dq[i]), 32'(exp_pr[i]));
            check_val($sformatf("prio_id%0d", i), 32'(iq[i]), 32'(exp_id[i]));
        end
        check_val("prio_turnaround", 32'(tq[2] - tq[1]), 32'd8);

        // Preempt: clip 0 at offset 10 is replaced by clip 3.
        clear_log();
        set_clip(SFX_MUSIC, 1000, 50);
        set_clip(SFX_DEATH, 2000, 5);
        pulse(4'b0001);
        wait_wr(10, 200, "pre_reach10");
        pulse(4'b1000);
        wait_busy(1'b0, 300, "pre_end");
        check_val("pre_count", 32'(dq.size()), 32'd15);
        check_val("pre_d9", 32'(dq[9]), 32'd32288);
        check_val("pre_d10", 32'(dq[10]), 32'd64000);
        check_val("pre_d14", 32'(dq[14]), 32'd64128);
        check_val("pre_id9", 32'(iq[9]), 32'd0);
        check_val("pre_id10", 32'(iq[10]), 32'd3);

        // Enable low for three ticks: offset holds, zeros written.
        clear_log();
        set_clip(SFX_EXPLODE, 700, 6);
        pulse(4'b0100);
        wait_wr(2, 100, "en_reach2");
        enable = 1'b0;
        cyc(12);
        check_val("en_busy_hold", 32'(busy), 32'd1);
        cyc(12);
        enable = 1'b1;
        wait_busy(1'b0, 200, "en_end");
        zeros = 0;
        nz.delete();
        foreach (dq[i]) begin
            if (dq[i] == 24'd0) zeros++;
            else nz.push_back(dq[i]);
        end
        check_val("en_zeros", 32'(zeros), 32'd3);
        check_val("en_nz_count", 32'(nz.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check_val($sformatf("en_d%0d", i), 32'(nz[i]), 32'((700 + i) * 32));
        end

        // Codec stall: one write on release, underrun set, no address skipped.
        clear_log();
        check_val("stall_pre_underrun", 32'(underrun), 32'd0);
        set_clip(SFX_BOMB, 500, 6);
        pulse(4'b0010);
        wait_wr(2, 100, "stall_reach2");
        bus.write_ready = 1'b0;
        cyc(20);
        check_val("stall_nowrite", 32'(dq.size()), 32'd2);
        bus.write_ready = 1'b1;
        cyc(2);
        check_val("stall_single", 32'(dq.size()), 32'd3);
        wait_busy(1'b0, 200, "stall_end");
        check_val("stall_count", 32'(dq.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check_val($sformatf("stall_d%0d", i), 32'(dq[i]), 32'((500 + i) * 32));
        end
        check_val("stall_underrun", 32'(underrun), 32'd1);

        // Reset held 5 cycles mid-clip.
        clear_log();
        set_clip(SFX_DEATH, 50, 40);
        pulse(4'b1000);
        wait_wr(3, 100, "mid_reach3");
        reset_n = 1'b0;
        cyc(5);
        check_val("mid_rst_write", 32'(bus.write), 32'd0);
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        check_val("mid_rst_rom_addr", 32'(bus.rom_addr), 32'd0);
        check_val("mid_rst_underrun", 32'(underrun), 32'd0);
        check_val("mid_rst_active_id", 32'(active_id), 32'd0);
        reset_n = 1'b1;
        m0 = dq.size();
        cyc(20);
        n0 = idle_n;
        cyc(32);
        check_val("post_rst_busy", 32'(busy), 32'd0);
        check_val("post_rst_no_clip", 32'(dq.size()), 32'(m0));
        check_val("post_rst_idle_writes", 32'(idle_n - n0), 32'd4);
        check_val("lr_identical", 32'(lr_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_n, failures_n);
        $finish;
    end

endmodule
